// File: rtl/iter_fft_pkg.sv
// Shared types and constant helpers for the iterative radix-2 FFT sequencer.
package iter_fft_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   function automatic int bf_per_layer(input int awl);
      return 1 << (awl - 1);
   endfunction

   // START-to-DONE distance in cycles, minus one for the START cycle itself.
   function automatic int total_cycles(input int awl, input int bf_lat);
      return awl * (bf_per_layer(awl) + bf_lat);
   endfunction

endpackage

// File: rtl/iter_fft_ctrl_if.sv
// Host / address-generator / memory signals of the FFT sequencer; master drives START side.
interface iter_fft_ctrl_if #(
   parameter int AWL = 5,
   parameter int LWL = 3
);
   logic           START;
   logic           ABORT;
   logic [AWL-1:0] A_ADDR;
   logic           BUSY;
   logic           DONE;
   logic           AG_CLR;
   logic           AG_EN;
   logic           AG_LAY_EN;
   logic           RD_EN;
   logic           WR_EN;
   logic [LWL-1:0] LAYER;
   logic [AWL-2:0] TW_ADDR;

   modport master (
      output START, ABORT, A_ADDR,
      input  BUSY, DONE, AG_CLR, AG_EN, AG_LAY_EN, RD_EN, WR_EN, LAYER, TW_ADDR
   );

   modport slave (
      input  START, ABORT, A_ADDR,
      output BUSY, DONE, AG_CLR, AG_EN, AG_LAY_EN, RD_EN, WR_EN, LAYER, TW_ADDR
   );
endinterface

// File: rtl/iter_fft_ctrl_valid_delay_line.sv
// DEPTH-cycle 1-bit valid delay with synchronous clear; turns read strobes into write strobes.
module valid_delay_line #(
   parameter int DEPTH = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic din,
   output logic dout
);

   logic [DEPTH-1:0] sr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   sr <= '0;
      else if (clr) sr <= '0;
      else          sr <= DEPTH'({sr, din});
   end

   assign dout = sr[DEPTH-1];

endmodule

// File: rtl/iter_fft_ctrl.sv
// Iterative radix-2 FFT sequencer: per layer a RUN burst then a BF_LAT drain gap, DONE pulse at the end.
// Define ITER_FFT_CTRL_TWIDDLE_EN to derive TW_ADDR from A_ADDR and LAYER; otherwise TW_ADDR is 0.
module iter_fft_ctrl
   import iter_fft_pkg::*;
#(
   parameter int AWL    = 5,
   parameter int BF_LAT = 3,
   parameter int LWL    = 3
) (
   input logic            CLK,
   input logic            RST,
   iter_fft_ctrl_if.slave bus
);

   localparam int               DCW        = (BF_LAT > 1) ? $clog2(BF_LAT) : 1;
   localparam logic [AWL-2:0]   BF_LAST    = (AWL-1)'(bf_per_layer(AWL) - 1);
   localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(BF_LAT - 1);
   localparam logic [LWL-1:0]   LAYER_LAST = LWL'(AWL - 1);

   state_t         state, state_nxt;
   logic [AWL-2:0] bf_cnt;
   logic [DCW-1:0] drain_cnt;
   logic [LWL-1:0] layer;
   logic           start_hit, abort_hit, run_last, drain_last;
   logic           busy, done, ag_clr, rd_en, lay_en, wr_en;

   assign start_hit  = (state == ST_IDLE) && bus.START;
   assign abort_hit  = ((state == ST_RUN) || (state == ST_DRAIN)) && bus.ABORT;
   assign run_last   = (state == ST_RUN) && (bf_cnt == BF_LAST);
   assign drain_last = (state == ST_DRAIN) && (drain_cnt == DRAIN_LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_nxt = state;
      busy      = 1'b0;
      done      = 1'b0;
      rd_en     = 1'b0;
      lay_en    = 1'b0;
      // Only the clear pulse looks at an input; gating with RST keeps it low during reset.
      ag_clr    = start_hit && RST;
      unique case (state)
         ST_IDLE: if (start_hit) state_nxt = ST_RUN;
         ST_RUN: begin
            busy   = 1'b1;
            rd_en  = 1'b1;
            lay_en = run_last;
            if (abort_hit)     state_nxt = ST_IDLE;
            else if (run_last) state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (abort_hit)       state_nxt = ST_IDLE;
            else if (drain_last) state_nxt = (layer == LAYER_LAST) ? ST_DONE : ST_RUN;
         end
         ST_DONE: begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         bf_cnt    <= '0;
         drain_cnt <= '0;
         layer     <= '0;
      end else if (start_hit) begin
         bf_cnt    <= '0;
         drain_cnt <= '0;
         layer     <= '0;
      end else if (!abort_hit) begin
         if (state == ST_RUN) bf_cnt <= bf_cnt + 1'b1;
         if (state == ST_DRAIN) begin
            drain_cnt <= drain_last ? '0 : drain_cnt + 1'b1;
            if (drain_last && (layer != LAYER_LAST)) layer <= layer + 1'b1;
         end
      end
   end

   // Abort flushes in-flight writes so no stale result lands after IDLE.
   valid_delay_line #(
      .DEPTH(BF_LAT)
   ) u_wr_dly (
      .clk  (CLK),
      .rst_n(RST),
      .clr  (abort_hit),
      .din  (rd_en),
      .dout (wr_en)
   );

   assign bus.BUSY      = busy;
   assign bus.DONE      = done;
   assign bus.AG_CLR    = ag_clr;
   assign bus.AG_EN     = rd_en;
   assign bus.AG_LAY_EN = lay_en;
   assign bus.RD_EN     = rd_en;
   assign bus.WR_EN     = wr_en;
   assign bus.LAYER     = layer;

`ifdef ITER_FFT_CTRL_TWIDDLE_EN
   logic [AWL-1:0] tw_mask, tw_full;
   always_comb begin
      tw_mask = ~({AWL{1'b1}} << layer);
      tw_full = (bus.A_ADDR & tw_mask) << (AWL - 1 - int'(layer));
   end
   assign bus.TW_ADDR = tw_full[AWL-2:0];
`else
   logic unused_a_addr;
   assign unused_a_addr = ^bus.A_ADDR;
   assign bus.TW_ADDR   = '0;
`endif

endmodule

// File: tb/tb_iter_fft_ctrl.sv
// Scoreboard bench for iter_fft_ctrl: a transform-level timing model queues per-cycle expectations.
module tb_iter_fft_ctrl;

   localparam int AWL    = 5;
   localparam int BF_LAT = 3;
   localparam int LWL    = 3;
   localparam int NB     = 1 << (AWL - 1);
   localparam int P      = NB + BF_LAT;

   typedef struct {
      int             cyc;
      logic [6:0]     flags;  // {BUSY, DONE, AG_CLR, AG_EN, AG_LAY_EN, RD_EN, WR_EN}
      logic [LWL-1:0] layer;
      logic [AWL-2:0] tw;
   } exp_t;

   logic CLK, RST;
   iter_fft_ctrl_if #(.AWL(AWL), .LWL(LWL)) bus ();

   iter_fft_ctrl #(.AWL(AWL), .BF_LAT(BF_LAT), .LWL(LWL)) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   exp_t q[$];
   int   n_vec = 0, n_fail = 0;
   int   n_wr = 0, n_lay = 0, n_done = 0, last_done = -1;
   int   d0, w0, l0, s;

   // Model state: is a transform in flight, when did it start, which layer did LAYER last show.
   bit             m_active = 1'b0;
   int             m_start  = 0;
   logic [LWL-1:0] m_layer  = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h, want %0h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [AWL-2:0] tw_ref(input int a, input int l);
`ifdef ITER_FFT_CTRL_TWIDDLE_EN
      int v;
      v = (a % (1 << l)) * (1 << (AWL - 1 - l));
      return (AWL-1)'(v);
`else
      return (AWL-1)'(a * l * 0);
`endif
   endfunction

   // Expected outputs for the current cycle, from the transform's elapsed time alone.
   task automatic model_step(input bit st, input bit ab, input int a, output exp_t e);
      int t, pos;
      e.cyc   = cyc;
      e.flags = '0;
      if (m_active) begin
         t = cyc - m_start - 1;
         if (t >= AWL * P) begin
            e.flags[5] = 1'b1;
            m_active   = 1'b0;
         end else begin
            pos        = t % P;
            m_layer    = LWL'(t / P);
            e.flags[6] = 1'b1;
            e.flags[3] = (pos < NB);
            e.flags[1] = (pos < NB);
            e.flags[2] = (pos == NB - 1);
            e.flags[0] = (pos >= BF_LAT);
            if (ab) m_active = 1'b0;
         end
      end else if (st) begin
         e.flags[4] = 1'b1;
         m_active   = 1'b1;
         m_start    = cyc;
      end
      e.layer = m_layer;
      e.tw    = tw_ref(a, int'(m_layer));
   endtask

   task automatic drive(input bit st, input bit ab, input bit rst_v);
      exp_t e;
      bit   was_up;
      @(posedge CLK);
      #1;
      bus.START  = st;
      bus.ABORT  = ab;
      bus.A_ADDR = AWL'($urandom);
      if (!rst_v) begin
         was_up   = (RST === 1'b1);
         RST      = 1'b0;
         m_active = 1'b0;
         m_layer  = '0;
         if (was_up) begin
            #1;
            check("async_rst_outputs",
                  {bus.BUSY, bus.DONE, bus.AG_CLR, bus.AG_EN, bus.AG_LAY_EN, bus.RD_EN,
                   bus.WR_EN, bus.LAYER, bus.TW_ADDR}, '0);
         end
         e.cyc = cyc; e.flags = '0; e.layer = '0; e.tw = '0;
      end else begin
         RST = 1'b1;
         model_step(st, ab, int'(bus.A_ADDR), e);
      end
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) drive(1'b0, 1'b0, 1'b1);
   endtask

   task automatic settle();
      @(negedge CLK);
      #1;
   endtask

   task automatic snap();
      d0 = n_done; w0 = n_wr; l0 = n_lay;
   endtask

   // Monitor: pops the expectation for the current cycle and compares, independent of stimulus.
   exp_t me;
   always @(negedge CLK) begin
      if (q.size() > 0 && q[0].cyc <= cyc) begin
         me = q.pop_front();
         if (me.cyc != cyc) check("sb_cycle_tag", me.cyc, cyc);
         else begin
            check("flags", {bus.BUSY, bus.DONE, bus.AG_CLR, bus.AG_EN, bus.AG_LAY_EN,
                            bus.RD_EN, bus.WR_EN}, me.flags);
            check("layer", bus.LAYER, me.layer);
            check("tw_addr", bus.TW_ADDR, me.tw);
         end
      end
      if (bus.WR_EN === 1'b1)     n_wr++;
      if (bus.AG_LAY_EN === 1'b1) n_lay++;
      if (bus.DONE === 1'b1) begin
         n_done++;
         last_done = cyc;
      end
   end

   initial begin
      RST = 1'b0; bus.START = 1'b0; bus.ABORT = 1'b0; bus.A_ADDR = '0;
      repeat (3) drive(1'b0, 1'b0, 1'b0);

      // Single START pulse in cycle 10: DONE in cycle 106.
      while (cyc + 1 < 10) idle(1);
      snap();
      drive(1'b1, 1'b0, 1'b1);
      idle(100);
      settle();
      check("s1_done_cycle", last_done, 106);
      check("s1_done_count", n_done - d0, 1);
      check("s1_wr_count", n_wr - w0, 80);
      check("s1_lay_count", n_lay - l0, 5);

      // ABORT at layer 2 butterfly 7, then a clean transform.
      drive(1'b1, 1'b0, 1'b1);
      s = cyc;
      while (cyc + 1 < s + 1 + 2 * P + 7) idle(1);
      snap();
      drive(1'b0, 1'b1, 1'b1);
      idle(5);
      settle();
      check("abort_no_done", n_done - d0, 0);
      snap();
      drive(1'b1, 1'b0, 1'b1);
      s = cyc;
      idle(100);
      settle();
      check("post_abort_done_cycle", last_done, s + 96);
      check("post_abort_wr_count", n_wr - w0, 80);

      // START held high: back-to-back transforms, one per START-in-IDLE.
      snap();
      repeat (220) drive(1'b1, 1'b0, 1'b1);
      idle(100);
      settle();
      check("held_start_done_count", n_done - d0, 3);

      // START pulses while BUSY are ignored.
      snap();
      drive(1'b1, 1'b0, 1'b1);
      repeat (95) drive(($urandom % 3) == 0, 1'b0, 1'b1);
      idle(10);
      settle();
      check("busy_start_done_count", n_done - d0, 1);

      // Reset in the DRAIN of layer 3, then a fresh transform.
      drive(1'b1, 1'b0, 1'b1);
      s = cyc;
      while (cyc + 1 < s + 1 + 3 * P + NB + 1) idle(1);
      snap();
      repeat (3) drive(1'b0, 1'b0, 1'b0);
      idle(10);
      settle();
      check("rst_no_done", n_done - d0, 0);
      snap();
      drive(1'b1, 1'b0, 1'b1);
      s = cyc;
      idle(100);
      settle();
      check("post_rst_done_cycle", last_done, s + 96);
      check("post_rst_done_count", n_done - d0, 1);

      // Random START/ABORT traffic against the model.
      repeat (600) drive(($urandom % 8) == 0, ($urandom % 40) == 0, 1'b1);
      idle(100);
      settle();
      check("sb_drained", q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule

// File: doc/iter_fft_ctrl.md
# iter_fft_ctrl

Sequencer for the in-place iterative radix-2 FFT datapath. Drives the butterfly address generator (address-step enable, layer-advance enable, synchronous clear), issues memory read/write enables around a fixed-latency butterfly pipeline, and inserts a drain gap between layers so layer s+1 never reads a bin before layer s has written it. Provides a START/BUSY/DONE handshake to the host and, optionally, the twiddle ROM address.

## Interface
Parameters:
- AWL, 5: address width; N = 2^AWL points, AWL layers, 2^(AWL-1) butterflies per layer. Legal range 2..12.
- BF_LAT, 3: read-to-write latency of the butterfly pipeline in cycles. Legal range 1..15.
- LWL, 3: layer index width; must satisfy 2^LWL >= AWL.

Ports:
- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- START  in  1  begin a transform; sampled only in IDLE.
- ABORT  in  1  cancel the transform in progress; ignored in IDLE.
- A_ADDR  in  AWL  A address from the address generator; twiddle computation only.
- BUSY  out  1  high in RUN and DRAIN.
- DONE  out  1  one-cycle completion pulse.
- AG_CLR  out  1  active-high synchronous clear to the address generator.
- AG_EN  out  1  address step enable.
- AG_LAY_EN  out  1  layer rotate enable.
- RD_EN  out  1  butterfly operand read enable.
- WR_EN  out  1  butterfly result write enable.
- LAYER  out  LWL  current layer, 0..AWL-1.
- TW_ADDR  out  AWL-1  twiddle ROM address.

## Operation
- States: IDLE, RUN, DRAIN, DONE. Reset enters IDLE.
- IDLE: if START, then AG_CLR=1 combinationally in that cycle, then -> RUN. Clear the butterfly counter and LAYER to 0.
- RUN: AG_EN=RD_EN=1 every cycle. The butterfly counter (AWL-1 bits) increments. On count 2^(AWL-1)-1, assert AG_LAY_EN=1 in that same cycle and -> DRAIN.
  - The address generator wraps to 0 by itself.
  - After AWL layer rotations its layer mask is back to 1.
- DRAIN: AG_EN=RD_EN=0 for exactly BF_LAT cycles (drain counter).
  - At the end, if LAYER==AWL-1 -> DONE.
  - Otherwise LAYER+1 -> RUN.
- DONE: DONE=1 for one cycle, BUSY=0, then -> IDLE.
- WR_EN: RD_EN delayed by exactly BF_LAT cycles through a shift register. The last write of each layer lands in the final DRAIN cycle.
- ABORT in RUN/DRAIN: -> IDLE next cycle. Zero the WR_EN shift register in the same edge. No DONE pulse. The next START re-clears the address generator via AG_CLR.
- START while not IDLE is ignored. START with ABORT in IDLE: START wins.
- Reset asserted mid-operation: immediately IDLE. Every output is 0 and every counter is 0.

## Timing
- Reset values: BUSY, DONE, AG_CLR, AG_EN, AG_LAY_EN, RD_EN, WR_EN, LAYER and TW_ADDR are all 0.
- START sampled at edge k: first RUN cycle is k+1.
- RUN lasts 2^(AWL-1) cycles per layer. DRAIN lasts BF_LAT cycles per layer.
- DONE is high in cycle k+1+AWL*(2^(AWL-1)+BF_LAT). For defaults: k+96.
- The earliest next START is accepted in the cycle after DONE.
- All outputs except AG_CLR and TW_ADDR are registered-state decodes with no input-to-output paths.

## Configuration
- Macro ITER_FFT_CTRL_TWIDDLE_EN.
  - Defined: TW_ADDR = (A_ADDR & ((1<<LAYER)-1)) << (AWL-1-LAYER), truncated to AWL-1 bits. This path is combinational. Layer 0 always gives 0.
  - Undefined: TW_ADDR is tied to 0 and A_ADDR is unused.

## Structure
- Package iter_fft_pkg holds:
  - the state encoding constants (IDLE, RUN, DRAIN, DONE);
  - helper constant functions for butterflies per layer and total cycle count.
- One sub-module, valid_delay_line: parameterised BF_LAT-deep 1-bit shift register with synchronous clear, used for WR_EN.

## Test plan
- Defaults, START pulse at edge 10: 16 AG_EN cycles, then 3 idle cycles, per layer ×5. AG_LAY_EN pulses 5 times, on each layer's 16th AG_EN cycle. DONE high only in cycle 106. WR_EN count = 80.
- WR_EN alignment: every WR_EN rising edge is exactly 3 cycles after an RD_EN rising edge. WR_EN is never high in the RUN cycle following a DRAIN.
- ABORT in layer 2, butterfly 7: next cycle IDLE, BUSY=0, WR_EN=0, no DONE. A following START runs a full 96-cycle transform with AG_CLR pulsed.
- START held high throughout: one transform per START-in-IDLE. A second run begins the cycle after DONE. START pulses during BUSY have no effect.
- RST low in DRAIN of layer 3: all outputs 0 asynchronously, no DONE after release. A fresh START gives normal timing.
- With ITER_FFT_CTRL_TWIDDLE_EN, LAYER=2, A_ADDR=5'b00011: TW_ADDR=4'b1100. With the macro undefined: TW_ADDR=0 throughout.
